// File: rtl/sprite_bitmap_writer_if.sv
// sprite_bitmap_writer_if: valid/ready pixel stream feeding the sprite bitmap writer
interface sprite_bitmap_writer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_rgb;
  logic        pix_transparent;
  modport master(output pix_valid, pix_rgb, pix_transparent, input pix_ready);
  modport slave(input pix_valid, pix_rgb, pix_transparent, output pix_ready);
endinterface

// File: rtl/sprite_bitmap_writer.sv
// sprite_bitmap_writer: loads a raster pixel stream into an RGB332 bitmap and serves it to the VGA mux
module sprite_bitmap_writer #(
  parameter int         OBJECT_WIDTH_X       = 25,
  parameter int         OBJECT_HEIGHT_Y      = 25,
  parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF,
  parameter logic [7:0] OPAQUE_SUBSTITUTE    = 8'hFE
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         start,
  sprite_bitmap_writer_if.slave        pix,
  output logic                         busy,
  output logic                         done,
  input  logic [10:0]                  offsetX,
  input  logic [10:0]                  offsetY,
  input  logic                         InsideRectangle,
  output logic                         drawingRequest,
  output logic [23:0]                  RGBout
);
  localparam int XW = $clog2(OBJECT_WIDTH_X);
  localparam int YW = $clog2(OBJECT_HEIGHT_Y);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t          state_q, state_d;
  logic [XW-1:0]   col_q, col_d;
  logic [YW-1:0]   row_q, row_d;
  logic            done_q, done_d, dreq_q, dreq_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            acc, eol, last, in_rng;
  logic [7:0]      raw, enc, c;
  // Codes are stored XORed with the transparent code so all-zero power-up contents read as transparent
  logic [7:0]      mem [OBJECT_HEIGHT_Y][OBJECT_WIDTH_X];
  assign pix.pix_ready   = state_q == LOAD;
  assign busy            = state_q == LOAD;
  assign done            = done_q;
  assign drawingRequest  = dreq_q;
  assign RGBout          = rgb_q;
  always_comb begin
    acc     = state_q == LOAD && pix.pix_valid;
    eol     = col_q == XW'(OBJECT_WIDTH_X - 1);
    last    = eol && row_q == YW'(OBJECT_HEIGHT_Y - 1);
    raw     = {pix.pix_rgb[23:21], pix.pix_rgb[15:13], pix.pix_rgb[7:6]};
    enc     = pix.pix_transparent ? TRANSPARENT_ENCODING :
              raw == TRANSPARENT_ENCODING ? OPAQUE_SUBSTITUTE : raw;
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? (acc && last ? DONE : LOAD) : IDLE;
    col_d   = state_q == IDLE ? '0 : acc ? (eol ? '0 : col_q + 1'b1) : col_q;
    row_d   = state_q == IDLE ? '0 : acc && eol ? row_q + 1'b1 : row_q;
    done_d  = state_d == DONE;
    in_rng  = offsetX < 11'(OBJECT_WIDTH_X) && offsetY < 11'(OBJECT_HEIGHT_Y);
    c       = in_rng ? mem[offsetY[YW-1:0]][offsetX[XW-1:0]] ^ TRANSPARENT_ENCODING : TRANSPARENT_ENCODING;
    rgb_d   = in_rng ? {c[7:5], 5'd0, c[4:2], 5'd0, c[1:0], 6'd0} : '0;
    dreq_d  = InsideRectangle && in_rng && c != TRANSPARENT_ENCODING;
  end
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      dreq_q  <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= done_d;
      dreq_q  <= dreq_d;
      rgb_q   <= rgb_d;
    end
  end
  always_ff @(posedge clk)
    if (acc && !resetN) mem[row_q][col_q] <= enc ^ TRANSPARENT_ENCODING;
endmodule

// File: tb/tb_sprite_bitmap_writer.sv
// tb_sprite_bitmap_writer: directed vectors for the sprite bitmap writer
module tb_sprite_bitmap_writer;
  logic        clk = 0, resetN = 1, start = 0, ins = 0;
  logic [10:0] ox = 0, oy = 0;
  logic        busy, done, dr;
  logic [23:0] rgb;
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = -1, acc_cnt = 0, last_acc = -1;
  int b0, d0;
  typedef struct {
    int          ph;
    logic [10:0] x, y;
    logic        ins, dr;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl[$];
  sprite_bitmap_writer_if pix();
  sprite_bitmap_writer dut (
    .clk(clk), .resetN(resetN), .start(start), .pix(pix),
    .busy(busy), .done(done), .offsetX(ox), .offsetY(oy),
    .InsideRectangle(ins), .drawingRequest(dr), .RGBout(rgb)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (pix.pix_valid && pix.pix_ready) begin acc_cnt++; last_acc = cyc; end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic add(input int p, input int x, input int y, input logic i, input logic d, input logic [23:0] c);
    tbl.push_back('{p, 11'(x), 11'(y), i, d, c});
  endtask
  function automatic logic [24:0] pix_of(input int ld, input int i);
    case (ld)
      1: return i == 0 ? {1'b0, 24'hE0E0C0} : i == 80 ? {1'b0, 24'hFFFFFF} :
                i == 624 ? {1'b1, 24'h123456} : {1'b0, 24'h204080};
      2: return i == 80 ? {1'b1, 24'hFFFFFF} : i == 24 ? {1'b0, 24'hA0C040} :
                i == 25 ? {1'b0, 24'h60A0C0} : {1'b0, 24'h402000};
      3: return {1'b0, 24'h00E040};
      default: return {1'b0, 24'hC00000};
    endcase
  endfunction
  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask
  task automatic stream(input int ld, input int n, input bit gap, input int kick);
    int k = 0, guard = 0;
    bit ph = 1;
    while (k < n && guard < 4000) begin
      {pix.pix_transparent, pix.pix_rgb} = pix_of(ld, k);
      pix.pix_valid = !gap || ph;
      start = k == kick;
      @(negedge clk);
      if (pix.pix_valid && pix.pix_ready) k++;
      @(posedge clk); #1;
      ph = !ph;
      guard++;
    end
    pix.pix_valid = 0;
    start = 0;
    chk($sformatf("accepts ld%0d", ld), k, n);
  endtask
  task automatic run_phase(input int p);
    foreach (tbl[i]) if (tbl[i].ph == p) begin
      @(posedge clk); #1;
      ox = tbl[i].x; oy = tbl[i].y; ins = tbl[i].ins;
      @(posedge clk); @(negedge clk);
      chk($sformatf("drawreq p%0d x%0d y%0d", p, ox, oy), dr, tbl[i].dr);
      chk($sformatf("rgb p%0d x%0d y%0d", p, ox, oy), rgb, tbl[i].rgb);
    end
  endtask
  task automatic check_load(input string nm, input int busy_exp);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({nm, " done_pulses"}, done_cnt - d0, 1);
    chk({nm, " done_after_last"}, done_cyc, last_acc + 1);
    chk({nm, " busy_cycles"}, busy_cnt - b0, busy_exp);
    chk({nm, " busy_idle"}, busy, 0);
  endtask
  initial begin
    pix.pix_valid = 0; pix.pix_rgb = 0; pix.pix_transparent = 0;
    add(0, 0, 0, 1, 0, 24'hE0E0C0);
    add(0, 25, 0, 1, 0, 24'h0);
    add(1, 0, 0, 1, 1, 24'hE0E080);
    add(1, 5, 3, 1, 1, 24'hE0E080);
    add(1, 1, 0, 1, 1, 24'h204080);
    add(1, 1, 0, 0, 0, 24'h204080);
    add(1, 0, 12, 1, 1, 24'h204080);
    add(1, 24, 24, 1, 0, 24'hE0E0C0);
    add(1, 25, 0, 1, 0, 24'h0);
    add(1, 0, 30, 1, 0, 24'h0);
    add(1, 2047, 2047, 1, 0, 24'h0);
    add(2, 5, 3, 1, 0, 24'hE0E0C0);
    add(2, 24, 0, 1, 1, 24'hA0C040);
    add(2, 0, 1, 1, 1, 24'h60A0C0);
    add(2, 23, 0, 1, 1, 24'h402000);
    add(2, 1, 1, 1, 1, 24'h402000);
    add(2, 24, 24, 1, 1, 24'h402000);
    add(3, 0, 0, 1, 1, 24'hC00000);
    add(3, 24, 1, 1, 1, 24'hC00000);
    add(3, 0, 2, 1, 1, 24'h00E040);
    add(3, 24, 3, 1, 1, 24'h00E040);
    add(3, 5, 3, 1, 1, 24'h00E040);
    add(3, 0, 4, 1, 1, 24'h402000);
    add(3, 24, 24, 1, 1, 24'h402000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst pix_ready", pix.pix_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst drawreq", dr, 0);
    chk("rst rgb", rgb, 0);
    @(posedge clk); #1 resetN = 0;
    run_phase(0);
    chk("idle pix_ready", pix.pix_ready, 0);
    chk("idle busy", busy, 0);
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start();
    stream(1, 625, 0, 300);
    check_load("load1", 625);
    run_phase(1);
    b0 = busy_cnt; d0 = done_cnt;
    pulse_start();
    stream(2, 625, 1, -1);
    check_load("load2", 1249);
    run_phase(2);
    d0 = done_cnt;
    pulse_start();
    stream(3, 100, 0, -1);
    resetN = 1;
    @(posedge clk); #1 resetN = 0;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    pulse_start();
    stream(4, 50, 0, -1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("reload still_loading", busy, 1);
    chk("reload no_done", done_cnt - d0, 0);
    run_phase(3);
    @(posedge clk); #1 resetN = 1;
    @(posedge clk); #1 resetN = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
